llpm_fifo_buffer: RTL and testbench
===================================

# llpm_fifo_buffer

Synchronous FIFO buffer stage with LLPM valid/backpressure handshakes on both sides. It sits directly downstream of a select vertex and registers the merged stream into a small circular buffer. This breaks the purely combinatorial `a_bp` → `x_bp` path through the select, and absorbs short stalls from the consumer. It produces an occupancy count for debug and credit logic.

## Interface
- `Width`, 8, data bits per token.
- `Depth`, 4, number of entries; power of two, ≥ 2.
- `CLog2Depth`, 2, log2(`Depth`); pointer width.

- `clk`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  one clock; reset is synchronous and active-high.
- `x`  in  `Width`  upstream data; meaningful only when `x_valid`=1.
- `x_valid`  in  1  upstream token present.
- `x_bp`  out  1  backpressure to upstream; 1 = token not accepted this cycle.
- `a`  out  `Width`  head-of-queue data; meaningful only when `a_valid`=1.
- `a_valid`  out  1  head token present.
- `a_bp`  in  1  backpressure from consumer.
- `count`  out  `CLog2Depth+1`  current occupancy, 0..`Depth`.

## Operation
- Handshake rule, both sides: a transfer occurs in any cycle where valid=1 and bp=0. Valid may be raised or dropped at any time. Data is sampled only on transfer.
- State:
  - `mem[Depth]` of `Width` bits.
  - `wr_ptr` and `rd_ptr`, `CLog2Depth` bits each.
  - `count`, `CLog2Depth+1` bits.
- Push:
  - Condition: `x_valid & ~x_bp`.
  - Action: `mem[wr_ptr]` ← `x`; `wr_ptr` ← `wr_ptr+1`.
- Pop:
  - Condition: `a_valid & ~a_bp`.
  - Action: `rd_ptr` ← `rd_ptr+1`.
- Pointers wrap modulo `Depth` through natural overflow. No explicit compare.
- Count update:
  - `count` ← `count + push − pop`.
  - Push and pop together leave `count` unchanged.
- Status decode:
  - `x_bp` = `reset | (count == Depth)`. Combinatorial from registered state only; no dependence on `a_bp`.
  - `a_valid` = `(count != 0)`. Registered-state decode.
  - `a` = `mem[rd_ptr]`. Value is don't-care when `a_valid`=0.
- Full (`count`=`Depth`):
  - Push is refused, even if a pop occurs in the same cycle.
  - `x_bp` falls the cycle after the pop.
- Empty (`count`=0):
  - No pop is possible.
  - A push is not visible on `a` in the same cycle; there is no combinatorial bypass.
- Ordering: strict FIFO. No token is dropped or duplicated.
- Reset:
  - `wr_ptr`, `rd_ptr` and `count` ← 0. `mem` contents are not reset.
  - A reset asserted mid-operation discards all queued tokens at the next edge.
  - While `reset`=1, `x_bp`=1, so upstream sees no acceptance.

## Timing
- Reset values, in the cycle after a reset edge with `reset` deasserted:
  - `count`=0, `a_valid`=0.
  - `x_bp`=0.
  - `a` = X, don't-care.
- Latency: a token pushed at edge *t* is presented on `a` with `a_valid`=1 from cycle *t+1*.
- Throughput: 1 token/cycle sustained whenever 0 < `count` < `Depth`, including simultaneous push and pop.
- `x_bp` and `a_valid` change only after clock edges, or combinationally with `reset`. Neither has a combinatorial path from `x_valid` or `a_bp`.
- `count` is registered and reflects all transfers completed at the prior edge.

## Test plan
- Reset then idle: after reset, `count`=0, `a_valid`=0, `x_bp`=0. With `reset`=1, `x_bp`=1.
- Fill to full, `Depth`=4, `a_bp`=1: push 0x11, 0x22, 0x33, 0x44.
  - `count` steps 1→4.
  - `x_bp`=1 after the 4th push.
  - A 5th token (0x55) held on `x` is not accepted.
- Full with simultaneous events: at `count`=4, set `a_bp`=0 with `x_valid`=1 carrying 0x55.
  - That cycle: pop of 0x11 only; `count`=3.
  - Next cycle: 0x55 is accepted.
  - Output order is 0x22, 0x33, 0x44, 0x55.
- Streaming and wrap-around: continuous push and pop of 0x00..0x0F, no backpressure.
  - `count` stays at 1.
  - One output per cycle, in order, after a 1-cycle initial latency.
  - Pointers wrap 4 times.
- Random valid/bp: 1000 tokens with random `x_valid` and `a_bp`.
  - Scoreboard: output sequence equals input sequence.
  - `count` always equals pushes − pops and is never > 4.
- Reset mid-operation: with 3 tokens queued, assert `reset` for 1 cycle.
  - Then `count`=0 and `a_valid`=0.
  - The next pushed token, 0xA5, is the first output.

Source files
------------

// File: rtl/llpm_fifo_buffer.sv
// Registered FIFO stage between a select vertex and its consumer: breaks the
// a_bp -> x_bp combinational path and absorbs short consumer stalls.
module llpm_fifo_buffer #(
    parameter int Width      = 8,
    parameter int Depth      = 4,
    parameter int CLog2Depth = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [Width-1:0]      x,
    input  logic                  x_valid,
    output logic                  x_bp,
    output logic [Width-1:0]      a,
    output logic                  a_valid,
    input  logic                  a_bp,
    output logic [CLog2Depth:0]   count
);

    localparam int CntW = CLog2Depth + 1;
    localparam logic [CLog2Depth:0] FullCnt = CntW'(Depth);

    logic [Width-1:0]      r_mem [Depth];
    logic [CLog2Depth-1:0] r_wr_ptr;
    logic [CLog2Depth-1:0] r_rd_ptr;
    logic [CLog2Depth:0]   r_count;
    logic [CLog2Depth:0]   w_count_next;
    logic                  w_push;
    logic                  w_pop;

    // Status decodes depend only on registered state (and reset), never on x_valid/a_bp.
    assign x_bp    = reset | (r_count == FullCnt);
    assign a_valid = (r_count != {CntW{1'b0}});
    assign a       = r_mem[r_rd_ptr];
    assign count   = r_count;

    assign w_push = x_valid & ~x_bp;
    assign w_pop  = a_valid & ~a_bp;

    // Occupancy next-state: simultaneous push and pop leave it unchanged.
    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CntW'(1);
            2'b01:   w_count_next = r_count - CntW'(1);
            default: w_count_next = r_count;
        endcase
    end

    // Pointer and occupancy registers; pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= {CLog2Depth{1'b0}};
            r_rd_ptr <= {CLog2Depth{1'b0}};
            r_count  <= {CntW{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + CLog2Depth'(1);
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + CLog2Depth'(1);
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end
            r_count <= w_count_next;
        end
    end

    // Storage array is deliberately not reset; only written on an accepted push.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= x;
        end
    end

endmodule

// File: tb/tb_llpm_fifo_buffer.sv
// Self-checking bench for llpm_fifo_buffer: constant vector table for the
// fill/full corner, plus a queue scoreboard for streaming, random and reset.
module tb_llpm_fifo_buffer;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] x;
    logic       x_valid;
    logic       x_bp;
    logic [7:0] a;
    logic       a_valid;
    logic       a_bp;
    logic [2:0] count;

    llpm_fifo_buffer #(.Width(8), .Depth(4), .CLog2Depth(2)) dut (
        .clk     (clk),
        .reset   (reset),
        .x       (x),
        .x_valid (x_valid),
        .x_bp    (x_bp),
        .a       (a),
        .a_valid (a_valid),
        .a_bp    (a_bp),
        .count   (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       xv;
        logic [7:0] xd;
        logic       abp;
        logic       use_exp;
        logic [2:0] e_cnt;
        logic       e_xbp;
        logic       e_av;
        logic       chk_a;
        logic [7:0] e_a;
    } vec_t;

    int         n_vec = 0;
    int         n_err = 0;
    int         n_push = 0;
    int         n_pop = 0;
    logic [7:0] sb [$];
    vec_t       tbl [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic xv, input logic [7:0] xd, input logic abp);
        vec_t v;
        v.rst = rst; v.xv = xv; v.xd = xd; v.abp = abp;
        v.use_exp = 1'b0; v.e_cnt = 3'd0; v.e_xbp = 1'b0; v.e_av = 1'b0;
        v.chk_a = 1'b0; v.e_a = 8'h00;
        return v;
    endfunction

    function automatic vec_t mke(input logic rst, input logic xv, input logic [7:0] xd, input logic abp,
                                 input logic [2:0] c, input logic xb, input logic av,
                                 input logic ca, input logic [7:0] ea);
        vec_t v;
        v = mk(rst, xv, xd, abp);
        v.use_exp = 1'b1; v.e_cnt = c; v.e_xbp = xb; v.e_av = av; v.chk_a = ca; v.e_a = ea;
        return v;
    endfunction

    // Drive one cycle, check outputs mid-cycle against the model (and table), then clock.
    task automatic step(input vec_t v);
        bit full;
        bit empty;
        reset = v.rst; x_valid = v.xv; x = v.xd; a_bp = v.abp;
        @(negedge clk);
        if (v.use_exp) begin
            chk("tbl_count", 32'(count), 32'(v.e_cnt));
            chk("tbl_x_bp", 32'(x_bp), 32'(v.e_xbp));
            chk("tbl_a_valid", 32'(a_valid), 32'(v.e_av));
            if (v.chk_a) chk("tbl_a", 32'(a), 32'(v.e_a));
        end
        full  = (sb.size() == 4);
        empty = (sb.size() == 0);
        chk("x_bp", 32'(x_bp), 32'(v.rst | full));
        chk("a_valid", 32'(a_valid), 32'(!empty));
        chk("count", 32'(count), 32'(sb.size()));
        if (v.rst) begin
            sb.delete();
        end else begin
            if (!empty && !v.abp) begin
                chk("a_data", 32'(a), 32'(sb[0]));
                void'(sb.pop_front());
                n_pop++;
            end
            if (v.xv && !full) begin
                sb.push_back(v.xd);
                n_push++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cyc;
        // Fill to full with a_bp=1, hold 0x55 while full, pop-at-full, then drain.
        tbl[0]  = mke(1'b1, 1'b0, 8'h00, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 8'h00);
        tbl[1]  = mke(1'b0, 1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00);
        tbl[2]  = mke(1'b0, 1'b1, 8'h11, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00);
        tbl[3]  = mke(1'b0, 1'b1, 8'h22, 1'b1, 3'd1, 1'b0, 1'b1, 1'b1, 8'h11);
        tbl[4]  = mke(1'b0, 1'b1, 8'h33, 1'b1, 3'd2, 1'b0, 1'b1, 1'b1, 8'h11);
        tbl[5]  = mke(1'b0, 1'b1, 8'h44, 1'b1, 3'd3, 1'b0, 1'b1, 1'b1, 8'h11);
        tbl[6]  = mke(1'b0, 1'b1, 8'h55, 1'b1, 3'd4, 1'b1, 1'b1, 1'b1, 8'h11);
        tbl[7]  = mke(1'b0, 1'b1, 8'h55, 1'b1, 3'd4, 1'b1, 1'b1, 1'b1, 8'h11);
        tbl[8]  = mke(1'b0, 1'b1, 8'h55, 1'b0, 3'd4, 1'b1, 1'b1, 1'b1, 8'h11);
        tbl[9]  = mke(1'b0, 1'b1, 8'h55, 1'b1, 3'd3, 1'b0, 1'b1, 1'b1, 8'h22);
        tbl[10] = mke(1'b0, 1'b0, 8'h00, 1'b0, 3'd4, 1'b1, 1'b1, 1'b1, 8'h22);
        tbl[11] = mke(1'b0, 1'b0, 8'h00, 1'b0, 3'd3, 1'b0, 1'b1, 1'b1, 8'h33);
        tbl[12] = mke(1'b0, 1'b0, 8'h00, 1'b0, 3'd2, 1'b0, 1'b1, 1'b1, 8'h44);
        tbl[13] = mke(1'b0, 1'b0, 8'h00, 1'b0, 3'd1, 1'b0, 1'b1, 1'b1, 8'h55);
        tbl[14] = mke(1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00);

        reset = 1'b1; x_valid = 1'b0; x = 8'h00; a_bp = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 15; i++) step(tbl[i]);

        // Streaming 0x00..0x0F with no backpressure: count settles at 1.
        for (int i = 0; i < 16; i++) begin
            step(mk(1'b0, 1'b1, 8'(i), 1'b0));
            chk("stream_count", 32'(count), 32'd1);
        end
        step(mk(1'b0, 1'b0, 8'h00, 1'b0));
        chk("stream_drained", 32'(count), 32'd0);

        // Random valid/backpressure until 1000 tokens pushed, then drain.
        n_push = 0;
        cyc = 0;
        while (n_push < 1000 && cyc < 20000) begin
            step(mk(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1))));
            cyc++;
        end
        chk("random_pushes_done", 32'(n_push >= 1000), 32'd1);
        cyc = 0;
        while (sb.size() != 0 && cyc < 20) begin
            step(mk(1'b0, 1'b0, 8'h00, 1'b0));
            cyc++;
        end
        chk("random_drain", 32'(count), 32'd0);

        // Reset with three tokens queued discards them; 0xA5 is next out.
        for (int i = 0; i < 3; i++) step(mk(1'b0, 1'b1, 8'(8'hC0 + 8'(i)), 1'b1));
        chk("pre_reset_count", 32'(count), 32'd3);
        step(mk(1'b1, 1'b1, 8'hEE, 1'b1));
        chk("post_reset_count", 32'(count), 32'd0);
        chk("post_reset_a_valid", 32'(a_valid), 32'd0);
        step(mk(1'b0, 1'b1, 8'hA5, 1'b1));
        chk("after_reset_head", 32'(a), 32'hA5);
        step(mk(1'b0, 1'b0, 8'h00, 1'b0));
        step(mk(1'b0, 1'b0, 8'h00, 1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
